// File: rtl/ballot_unit.sv
// ballot_unit: voter-side ballot unit arming one clean candidate code per ballot.
`timescale 1ns/1ps
module ballot_unit #(
  parameter int NUM_CAND = 15,
  parameter int HOLD_CYC = 2,
  parameter int TIMEOUT  = 64
) (
  input  logic                clk,
  input  logic                Power,
  input  logic                Ballot,
  input  logic                Lock,
  input  logic                Clear,
  input  logic [NUM_CAND-1:0] Key,
  output logic [3:0]          IN,
  output logic                Ready,
  output logic                Invalid,
  output logic                Tout,
  output logic [11:0]         Sent_cnt
);
  localparam int TW = $clog2(TIMEOUT);
  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  typedef enum logic [2:0] {IDLE, ARMED, WAIT_KEY, SEND, GAP} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [3:0] in_q, in_d, code;
  logic ready_q, ready_d, invalid_q, invalid_d, tout_q, tout_d, ballot_prev_q;
  logic [11:0] sent_q, sent_d;
  logic any_key, one_hot, ballot_ev, sent_inc, timer_end;
  always_comb begin
    code = '0;
    for (int i = 0; i < NUM_CAND; i++)
      if (Key[i]) code = 4'(i + 1);
  end
  assign any_key   = |Key;
  assign one_hot   = any_key && ((Key & (Key - NUM_CAND'(1))) == '0);
  assign ballot_ev = Ballot && !ballot_prev_q;
  assign timer_end = timer_q == TW'(TIMEOUT - 1);
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    hold_d    = hold_q;
    in_d      = in_q;
    invalid_d = 1'b0;
    tout_d    = 1'b0;
    sent_inc  = 1'b0;
    case (state_q)
      IDLE: begin
        in_d    = '0;
        timer_d = '0;
        if (ballot_ev && !Lock) state_d = ARMED;
      end
      ARMED: state_d = Lock ? IDLE : (!any_key ? WAIT_KEY : ARMED);
      WAIT_KEY: begin
        // Saturating so an Invalid retry never wraps the ballot's time budget.
        timer_d = timer_end ? timer_q : timer_q + 1'b1;
        if (Lock) state_d = IDLE;
        else if (one_hot) begin
          state_d = SEND;
          in_d    = code;
          hold_d  = '0;
        end else if (any_key) begin
          state_d   = ARMED;
          invalid_d = 1'b1;
        end else if (timer_end) begin
          state_d = IDLE;
          tout_d  = 1'b1;
        end
      end
      SEND: begin
        if (hold_q == HW'(HOLD_CYC - 1)) begin
          state_d  = GAP;
          in_d     = '0;
          sent_inc = 1'b1;
        end else hold_d = hold_q + 1'b1;
      end
      GAP: state_d = any_key ? GAP : IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = state_d == WAIT_KEY;
    sent_d  = Clear ? '0 : (sent_inc && sent_q != '1) ? sent_q + 12'd1 : sent_q;
  end
  always_ff @(posedge clk) begin
    if (!Power) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      hold_q        <= '0;
      in_q          <= '0;
      ready_q       <= 1'b0;
      invalid_q     <= 1'b0;
      tout_q        <= 1'b0;
      sent_q        <= '0;
      ballot_prev_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      hold_q        <= hold_d;
      in_q          <= in_d;
      ready_q       <= ready_d;
      invalid_q     <= invalid_d;
      tout_q        <= tout_d;
      sent_q        <= sent_d;
      ballot_prev_q <= Ballot;
    end
  end
  assign IN       = in_q;
  assign Ready    = ready_q;
  assign Invalid  = invalid_q;
  assign Tout     = tout_q;
  assign Sent_cnt = sent_q;
endmodule

// File: tb/tb_ballot_unit.sv
// tb_ballot_unit: directed and randomized checks of ballot_unit against a vote-level model.
`timescale 1ns/1ps
module tb_ballot_unit;
  logic clk = 1'b0, Power = 1'b0, Ballot = 1'b0, Lock = 1'b0, Clear = 1'b0;
  logic [14:0] Key = '0;
  logic [3:0] IN;
  logic Ready, Invalid, Tout;
  logic [11:0] Sent_cnt;
  int checks = 0, passes = 0, fails = 0, exp_sent = 0;

  ballot_unit dut (
    .clk(clk), .Power(Power), .Ballot(Ballot), .Lock(Lock), .Clear(Clear), .Key(Key),
    .IN(IN), .Ready(Ready), .Invalid(Invalid), .Tout(Tout), .Sent_cnt(Sent_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Officer pulse from IDLE with keys released: ARMED, then WAIT_KEY.
  task automatic arm();
    Ballot = 1'b1;
    tick();
    Ballot = 1'b0;
    chk("arm_ready_lo", Ready, 0);
    tick();
    chk("arm_ready_hi", Ready, 1);
  endtask

  // Press candidate idx from WAIT_KEY, release, and let the vote finish to IDLE.
  task automatic send(input int idx, input bit clr);
    Key = '0;
    Key[idx] = 1'b1;
    tick();
    chk("send_in0", IN, idx + 1);
    chk("send_ready", Ready, 0);
    chk("send_tout", Tout, 0);
    chk("send_inv", Invalid, 0);
    Key = '0;
    tick();
    chk("send_in1", IN, idx + 1);
    Clear = clr;
    tick();
    Clear = 1'b0;
    exp_sent = clr ? 0 : (exp_sent < 4095 ? exp_sent + 1 : 4095);
    chk("send_in_gap", IN, 0);
    chk("send_cnt", Sent_cnt, exp_sent);
    tick();
  endtask

  initial begin
    Ballot = 1'b1;
    tick();
    tick();
    chk("rst_in", IN, 0);
    chk("rst_ready", Ready, 0);
    chk("rst_cnt", Sent_cnt, 0);
    chk("rst_inv", Invalid, 0);
    chk("rst_tout", Tout, 0);
    Power = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_held_ballot", Ready, 0);
    end
    Ballot = 1'b0;
    tick();
    tick();
    chk("rst_no_arm", Ready, 0);

    arm();
    send(4, 1'b0);

    arm();
    Key = 15'b101;
    tick();
    chk("multi_inv", Invalid, 1);
    chk("multi_in", IN, 0);
    chk("multi_ready", Ready, 0);
    Key = '0;
    tick();
    chk("multi_inv_end", Invalid, 0);
    chk("multi_ready_back", Ready, 1);
    send(0, 1'b0);

    Key = 15'b10;
    Ballot = 1'b1;
    tick();
    Ballot = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stuck_ready", Ready, 0);
    end
    Key = '0;
    tick();
    chk("stuck_release", Ready, 1);
    send(1, 1'b0);

    arm();
    for (int k = 1; k <= 64; k++) begin
      tick();
      chk("to_tout", Tout, k == 64);
      chk("to_ready", Ready, k < 64);
      chk("to_in", IN, 0);
    end
    tick();
    chk("to_pulse_end", Tout, 0);

    arm();
    repeat (63) tick();
    send(6, 1'b0);

    arm();
    Lock = 1'b1;
    tick();
    chk("lock_ready", Ready, 0);
    chk("lock_in", IN, 0);
    chk("lock_tout", Tout, 0);
    Ballot = 1'b1;
    tick();
    Ballot = 1'b0;
    tick();
    tick();
    chk("lock_ignore", Ready, 0);
    Lock = 1'b0;
    tick();
    tick();
    chk("lock_no_queue", Ready, 0);

    arm();
    Key = '0;
    Key[3] = 1'b1;
    tick();
    Lock = 1'b1;
    Key = '0;
    tick();
    chk("lock_send_in", IN, 4);
    tick();
    exp_sent++;
    chk("lock_send_gap", IN, 0);
    chk("lock_send_cnt", Sent_cnt, exp_sent);
    Lock = 1'b0;
    tick();

    for (int n = 0; n < 40; n++) begin
      int idx, d, a, b;
      idx = $urandom_range(0, 14);
      d = $urandom_range(0, 70);
      arm();
      if (d <= 60 && $urandom_range(0, 3) == 0) begin
        a = $urandom_range(0, 14);
        b = (a + $urandom_range(1, 14)) % 15;
        Key = '0;
        Key[a] = 1'b1;
        Key[b] = 1'b1;
        tick();
        chk("rnd_inv", Invalid, 1);
        Key = '0;
        tick();
        chk("rnd_inv_ready", Ready, 1);
      end
      if (d < 64) begin
        for (int k = 0; k < d; k++) begin
          tick();
          chk("rnd_wait_tout", Tout, 0);
          chk("rnd_wait_in", IN, 0);
        end
        send(idx, 1'b0);
      end else begin
        for (int k = 1; k <= 64; k++) begin
          tick();
          chk("rnd_tout", Tout, k == 64);
        end
        tick();
        chk("rnd_tout_cnt", Sent_cnt, exp_sent);
      end
    end

    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    exp_sent = 0;
    chk("clear_cnt", Sent_cnt, 0);

    for (int n = 0; n < 4096; n++) begin
      arm();
      send(n % 15, 1'b0);
    end
    chk("sat_cnt", Sent_cnt, 4095);
    arm();
    send(2, 1'b1);
    chk("clear_on_inc", Sent_cnt, 0);
    arm();
    send(5, 1'b0);
    chk("after_clear", Sent_cnt, 1);

    arm();
    Key = '0;
    Key[7] = 1'b1;
    tick();
    chk("midrst_in", IN, 8);
    Power = 1'b0;
    Key = '0;
    tick();
    exp_sent = 0;
    chk("midrst_in0", IN, 0);
    chk("midrst_ready", Ready, 0);
    chk("midrst_cnt", Sent_cnt, exp_sent);
    Power = 1'b1;
    tick();
    tick();
    chk("midrst_idle", IN, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
